score_timer: RTL
================

Name: score_timer

Overview:
- Game-control stage directly downstream of the rockets block.
- Consumes the SCORE_1/SCORE_2 arrival flags and keeps two BCD player scores.
- Runs the game countdown timer and drives GAME_ON and R_RESET back into the rockets block.
- Feeds score digits and the timer value to the score/timer-bar video logic.

Parameters:
- TIMER_STEPS, 64, countdown length in steps; also timer-bar height.
- FRAMES_PER_STEP, 42, frames per timer decrement (64×42 frames ≈ 45 s at 60 Hz).

Ports:
- CLK_DRV  in  1  system clock; all logic on posedge.
- RESET  in  1  asynchronous, active-high reset.
- VRESET_N  in  1  vertical reset, active low; a falling edge marks a frame tick.
- START_N  in  1  start/coin button, active low.
- SCORE_1  in  1  rocket 1 reached top (level, from rockets block).
- SCORE_2  in  1  rocket 2 reached top (level).
- GAME_ON  out  1  high while in PLAY.
- R_RESET  out  1  rocket-counter clear request, high for the CLEAR frame.
- SCORE1_TENS, SCORE1_ONES  out  4 each  player 1 BCD digits.
- SCORE2_TENS, SCORE2_ONES  out  4 each  player 2 BCD digits.
- TIMER  out  $clog2(TIMER_STEPS+1)  remaining steps.
- GAME_OVER  out  1  one-cycle pulse when TIMER reaches 0.

Behaviour:
- Clock and reset: one clock domain (CLK_DRV). Reset is asynchronous and active-high (RESET).
- Reset values:
  - state = ATTRACT, scores = 00/00, TIMER = TIMER_STEPS.
  - GAME_ON = 0, R_RESET = 0, GAME_OVER = 0.
  - Frame-step counter = 0, all edge-detect registers = inactive.
- Input conditioning: VRESET_N, START_N, SCORE_1 and SCORE_2 each pass through a 2-flop synchroniser, then a registered edge detector.
  - frame_tick = falling edge of VRESET_N.
  - start = falling edge of START_N.
  - scN = rising edge of SCORE_N.
  - Event latency is 3 cycles from the input edge.
- States:
  - ATTRACT: scores hold their last game's values. On start → ARM.
  - ARM: waits for the next frame_tick → CLEAR.
  - CLEAR: R_RESET = 1. Scores are zeroed on entry, TIMER = TIMER_STEPS, step counter = 0. The next frame_tick → PLAY, and R_RESET drops in the same cycle. CLEAR therefore lasts exactly one full frame.
  - PLAY: GAME_ON = 1.
    - Each frame_tick increments the step counter.
    - When the counter reaches FRAMES_PER_STEP−1 on a tick, it resets to 0 and TIMER decrements.
    - When TIMER goes from 1 to 0: GAME_OVER pulses for 1 cycle and the state goes to ATTRACT. GAME_ON falls the cycle after TIMER = 0 is registered.
- Scoring:
  - sc1/sc2 increment the matching BCD score only in PLAY.
  - Ones digit wraps 9→0 and carries into tens.
  - A score from 99 follows the optional-feature rule below.
  - sc1 and sc2 in the same cycle: both scores increment.
  - A score edge in the same cycle as the final TIMER decrement still counts.
  - A score edge outside PLAY is discarded.
  - A level held high counts once; it must fall before the next increment.
- Start outside ATTRACT is ignored. A START_N held low across game end does not restart the game; a new falling edge is required.
- RESET asserted mid-game: immediate return to the reset values; no GAME_OVER pulse.
- FRAMES_PER_STEP = 1 is legal: TIMER decrements on every tick.

Optional Feature:
- Macro: SCORE_SATURATE_EN.
- Defined: a score at 99 holds at 99 on further increments.
- Undefined: 99 wraps to 00.
- Digits never leave the 0–9 range in either build.

Decomposition:
- Package space_race_pkg holds:
  - typedef enum state_t {ATTRACT, ARM, CLEAR, PLAY}.
  - typedef logic [3:0] bcd_t.
  - BCD_MAX = 4'd9.
- Sub-module bcd_score_counter (one instance per player):
  - Inputs: clear, inc.
  - Outputs: tens, ones.
  - Contains the saturate/wrap logic under SCORE_SATURATE_EN.
- FSM, timer, synchronisers and edge detectors live in score_timer.

Test Plan (TIMER_STEPS=4, FRAMES_PER_STEP=2, 100-cycle frames):
- Reset then idle for 5 frames → ATTRACT, GAME_ON=0, R_RESET=0, TIMER=4, scores 00/00.
- START_N pulse low → R_RESET high for exactly one frame (tick to tick), then GAME_ON=1. TIMER steps 4,3,2,1,0 every 2 frames. GAME_OVER is a single 1-cycle pulse. GAME_ON=0 afterwards; scores are retained in ATTRACT.
- In PLAY, SCORE_1 high for 50 cycles, 3 times → P1 = 03, P2 = 00. SCORE_2 rises in the same cycle as one SCORE_1 rise → both scores increment.
- Preload P1 by 99 scores → 99. One more score gives 99 with SCORE_SATURATE_EN, 00 without.
- SCORE_2 pulses during ATTRACT and CLEAR → no change. START_N pulse during PLAY → no effect on TIMER or state.
- RESET asserted mid-PLAY with TIMER=2 and P1=05 → outputs return to reset values asynchronously with no GAME_OVER. A new start runs a full 4-step game.

Source files
------------

// File: rtl/space_race_pkg.sv
// space_race_pkg: shared state encoding, BCD digit type and digit limit for the game-control stage.
package space_race_pkg;
  typedef enum logic [1:0] {ATTRACT, ARM, CLEAR, PLAY} state_t;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_score_counter.sv
// bcd_score_counter: two-digit BCD player score; 99 holds with SCORE_SATURATE_EN defined, else wraps to 00.
module bcd_score_counter
  import space_race_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output bcd_t tens,
  output bcd_t ones
);
  bcd_t tens_q, tens_d, ones_q, ones_d;
  logic bump, ones_wrap;
`ifdef SCORE_SATURATE_EN
  assign bump = inc && !(tens_q == BCD_MAX && ones_q == BCD_MAX);
`else
  assign bump = inc;
`endif
  assign ones_wrap = ones_q == BCD_MAX;
  always_comb begin
    ones_d = clear ? '0 : bump ? (ones_wrap ? '0 : ones_q + 4'd1) : ones_q;
    tens_d = clear ? '0 : (bump && ones_wrap) ? (tens_q == BCD_MAX ? '0 : tens_q + 4'd1) : tens_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end
  assign tens = tens_q;
  assign ones = ones_q;
endmodule

// File: rtl/score_timer.sv
// score_timer: game FSM, countdown timer and BCD scores downstream of the rockets block.
// Score saturation at 99 is selected by the SCORE_SATURATE_EN macro (wraps to 00 when undefined).
module score_timer
  import space_race_pkg::*;
#(
  parameter int TIMER_STEPS     = 64,
  parameter int FRAMES_PER_STEP = 42
) (
  input  logic                               CLK_DRV,
  input  logic                               RESET,
  input  logic                               VRESET_N,
  input  logic                               START_N,
  input  logic                               SCORE_1,
  input  logic                               SCORE_2,
  output logic                               GAME_ON,
  output logic                               R_RESET,
  output bcd_t                               SCORE1_TENS,
  output bcd_t                               SCORE1_ONES,
  output bcd_t                               SCORE2_TENS,
  output bcd_t                               SCORE2_ONES,
  output logic [$clog2(TIMER_STEPS+1)-1:0]   TIMER,
  output logic                               GAME_OVER
);
  localparam int TW = $clog2(TIMER_STEPS + 1);
  localparam int SW = $clog2(FRAMES_PER_STEP + 1);
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] step_q, step_d;
  logic [3:0] raw, meta_q, sync_q, prev_q, evt;
  logic tick, start, sc1, sc2, enter_clear, play_tick, step_wrap;
  // Active-low inputs are inverted so every conditioning flop resets to 0 (inactive).
  assign raw = {SCORE_2, SCORE_1, ~START_N, ~VRESET_N};
  always_ff @(posedge CLK_DRV or posedge RESET) begin
    if (RESET) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end
  assign evt   = sync_q & ~prev_q;
  assign tick  = evt[0];
  assign start = evt[1];
  assign sc1   = evt[2];
  assign sc2   = evt[3];
  always_ff @(posedge CLK_DRV or posedge RESET) begin
    if (RESET) state_q <= ATTRACT;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ATTRACT: if (start) state_d = ARM;
      ARM:     if (tick) state_d = CLEAR;
      CLEAR:   if (tick) state_d = PLAY;
      PLAY:    if (timer_q == '0) state_d = ATTRACT;
    endcase
  end
  always_comb begin
    GAME_ON   = state_q == PLAY;
    R_RESET   = state_q == CLEAR;
    GAME_OVER = state_q == PLAY && timer_q == '0;
  end
  assign enter_clear = state_q == ARM && tick;
  assign play_tick   = state_q == PLAY && tick;
  assign step_wrap   = step_q == SW'(FRAMES_PER_STEP - 1);
  // PLAY holds one extra cycle at TIMER=0 to emit GAME_OVER; the guard stops an underflow there.
  always_comb begin
    step_d  = enter_clear ? '0 : play_tick ? (step_wrap ? '0 : step_q + SW'(1)) : step_q;
    timer_d = enter_clear ? TW'(TIMER_STEPS)
            : (play_tick && step_wrap && timer_q != '0) ? timer_q - TW'(1) : timer_q;
  end
  always_ff @(posedge CLK_DRV or posedge RESET) begin
    if (RESET) begin
      timer_q <= TW'(TIMER_STEPS);
      step_q  <= '0;
    end else begin
      timer_q <= timer_d;
      step_q  <= step_d;
    end
  end
  assign TIMER = timer_q;
  bcd_score_counter u_p1 (
    .clk   (CLK_DRV),
    .rst   (RESET),
    .clear (enter_clear),
    .inc   (sc1 && state_q == PLAY),
    .tens  (SCORE1_TENS),
    .ones  (SCORE1_ONES)
  );
  bcd_score_counter u_p2 (
    .clk   (CLK_DRV),
    .rst   (RESET),
    .clear (enter_clear),
    .inc   (sc2 && state_q == PLAY),
    .tens  (SCORE2_TENS),
    .ones  (SCORE2_ONES)
  );
endmodule
